// File: rtl/axi_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_bridge_pkg
// Description : Shared types and AXI3 constants for the SRAM-to-AXI bridges.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4
    } bridge_state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [3:0] LEN_SINGLE = 4'd0;

    localparam logic [1:0] SIZE_BYTE  = 2'b00;
    localparam logic [1:0] SIZE_HALF  = 2'b01;
    localparam logic [1:0] SIZE_WORD  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/axi_wstrb_dec.sv
`default_nettype none
// ============================================================================
// Module      : axi_wstrb_dec
// Description : Byte-lane strobe decoder from access size and low address.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_wstrb_dec
    import axi_bridge_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] wstrb
);

    always_comb begin
        wstrb = 4'b1111;
        case (size)
            SIZE_BYTE: wstrb = 4'b0001 << addr_lo;
            SIZE_HALF: wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:   wstrb = 4'b1111;   // size 11 behaves as a word
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/d_sram2axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : d_sram2axi_bridge
// Description : Data-cache SRAM-like port to single-beat AXI3 master bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module d_sram2axi_bridge
    import axi_bridge_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd1,
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic              bus_err,
    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [3:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic [1:0]        arlock,
    output logic [3:0]        arcache,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,
    input  logic [3:0]        rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic [3:0]        awid,
    output logic [ADDR_W-1:0] awaddr,
    output logic [3:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic [1:0]        awlock,
    output logic [3:0]        awcache,
    output logic [2:0]        awprot,
    output logic              awvalid,
    input  logic              awready,
    output logic [3:0]        wid,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic [3:0]        bid,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    bridge_state_t     r_state;
    bridge_state_t     w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic [DATA_W-1:0] r_wdata;
    logic [3:0]        r_wstrb;
    logic [DATA_W-1:0] r_rdata;
    logic              r_aw_done;
    logic              r_w_done;
    logic              r_data_ok;
    logic              r_bus_err;
    logic [3:0]        w_wstrb;
    logic              w_wr_both;
    logic              w_unused;

    // Single outstanding transaction, so IDs and rlast carry no information.
    assign w_unused = ^{rid, bid, rlast};

    axi_wstrb_dec u_wstrb_dec (
        .size    (data_size),
        .addr_lo (data_addr[1:0]),
        .wstrb   (w_wstrb)
    );

    assign w_wr_both = (r_aw_done || (awvalid && awready)) &&
                       (r_w_done  || (wvalid  && wready));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        data_addr_ok = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                data_addr_ok = data_req;
                if (data_req) w_next_state = data_wr ? ST_WR_REQ : ST_RD_ADDR;
            end
            ST_RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) w_next_state = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                rready = 1'b1;
                if (rvalid) w_next_state = ST_IDLE;
            end
            ST_WR_REQ: begin
                awvalid = !r_aw_done;
                wvalid  = !r_w_done;
                if (w_wr_both) w_next_state = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                bready = 1'b1;
                if (bvalid) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr    <= '0;
            r_size    <= 2'b00;
            r_wdata   <= '0;
            r_wstrb   <= 4'b0000;
            r_rdata   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_data_ok <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_data_ok <= 1'b0;
            r_bus_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (data_req) begin
                        r_addr  <= data_addr;
                        r_size  <= data_size;
                        r_wdata <= data_wdata;
                        r_wstrb <= w_wstrb;
                    end
                end
                ST_RD_DATA: begin
                    if (rvalid) begin
                        r_rdata   <= rdata;
                        r_data_ok <= 1'b1;
                        r_bus_err <= (rresp != RESP_OKAY);
                    end
                end
                ST_WR_REQ: begin
                    if (w_wr_both) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end else begin
                        if (awvalid && awready) r_aw_done <= 1'b1;
                        if (wvalid && wready)   r_w_done  <= 1'b1;
                    end
                end
                ST_WR_RESP: begin
                    if (bvalid) begin
                        r_data_ok <= 1'b1;
                        r_bus_err <= (bresp != RESP_OKAY);
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_rdata   = r_rdata;
    assign data_data_ok = r_data_ok;
    assign bus_err      = r_bus_err;

    assign arid    = AXI_ID;
    assign araddr  = r_addr;
    assign arlen   = LEN_SINGLE;
    assign arsize  = {1'b0, r_size};
    assign arburst = BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;

    assign awid    = AXI_ID;
    assign awaddr  = r_addr;
    assign awlen   = LEN_SINGLE;
    assign awsize  = {1'b0, r_size};
    assign awburst = BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;

    assign wid     = AXI_ID;
    assign wdata   = r_wdata;
    assign wstrb   = r_wstrb;
    assign wlast   = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_d_sram2axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_d_sram2axi_bridge
// Description : Directed self-checking bench for d_sram2axi_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_d_sram2axi_bridge;

    logic        clk;
    logic        rst;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        data_addr_ok, data_data_ok, bus_err;
    logic [3:0]  arid, arlen, arcache;
    logic [31:0] araddr;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, arlock;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic [3:0]  awid, awlen, awcache;
    logic [31:0] awaddr;
    logic [2:0]  awsize, awprot;
    logic [1:0]  awburst, awlock;
    logic        awvalid, awready;
    logic [3:0]  wid, wstrb;
    logic [31:0] wdata;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    int n_pass  = 0;
    int n_total = 0;

    d_sram2axi_bridge dut (
        .clk(clk), .rst(rst),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .bus_err(bus_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic test_reset;
        rst = 1'b0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
        awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
        @(negedge clk); @(negedge clk); #1;
        n_total++;
        if ({arvalid, awvalid, wvalid, rready, bready, data_data_ok, bus_err, data_rdata, data_addr_ok} !== 40'h0)
            $display("FAIL reset_outputs got=%h required=0",
                     {arvalid, awvalid, wvalid, rready, bready, data_data_ok, bus_err, data_rdata, data_addr_ok});
        else n_pass++;
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_read_basic;
        @(negedge clk); data_req = 1; data_wr = 0; data_size = 2'b10; data_addr = 32'h0000_1004; arready = 1; #1;
        n_total++;
        if ({data_addr_ok, arvalid} !== 2'b10) $display("FAIL rd_addr_ok got=%b required=10", {data_addr_ok, arvalid});
        else n_pass++;
        @(negedge clk); data_req = 0; #1;
        n_total++;
        if ({arvalid, araddr, arsize, arlen, arburst, arid} !== {1'b1, 32'h0000_1004, 3'b010, 4'd0, 2'b01, 4'd1})
            $display("FAIL rd_ar got=%b_%h_%b_%h_%b_%h required=1_00001004_010_0_01_1", arvalid, araddr, arsize, arlen, arburst, arid);
        else n_pass++;
        @(negedge clk); arready = 0; rvalid = 1; rdata = 32'hDEAD_BEEF; rresp = 2'b00; #1;
        n_total++;
        if ({rready, arvalid, data_data_ok} !== 3'b100) $display("FAIL rd_rready got=%b required=100", {rready, arvalid, data_data_ok});
        else n_pass++;
        @(negedge clk); rvalid = 0; #1;
        n_total++;
        if ({data_data_ok, bus_err, data_rdata} !== {2'b10, 32'hDEAD_BEEF})
            $display("FAIL rd_data_ok got=%b%b_%h required=10_deadbeef", data_data_ok, bus_err, data_rdata);
        else n_pass++;
        @(negedge clk); #1;
        n_total++;
        if ({data_data_ok, rready, data_rdata} !== {2'b00, 32'hDEAD_BEEF})
            $display("FAIL rd_hold got=%b%b_%h required=00_deadbeef", data_data_ok, rready, data_rdata);
        else n_pass++;
    endtask

    task automatic test_byte_write;
        @(negedge clk); data_req = 1; data_wr = 1; data_size = 2'b00; data_addr = 32'h0000_2003;
        data_wdata = 32'hAB00_0000; awready = 1; wready = 1; #1;
        n_total++;
        if (data_addr_ok !== 1'b1) $display("FAIL wr_addr_ok got=%b required=1", data_addr_ok);
        else n_pass++;
        @(negedge clk); data_req = 0; #1;
        n_total++;
        if ({awvalid, wvalid, awaddr, awsize, wstrb, wlast, wdata} !== {2'b11, 32'h0000_2003, 3'b000, 4'b1000, 1'b1, 32'hAB00_0000})
            $display("FAIL wr_aw_w got=%b_%h_%b_%b_%b_%h required=11_00002003_000_1000_1_ab000000",
                     {awvalid, wvalid}, awaddr, awsize, wstrb, wlast, wdata);
        else n_pass++;
        @(negedge clk); bvalid = 1; bresp = 2'b00; #1;
        n_total++;
        if ({bready, awvalid, wvalid} !== 3'b100) $display("FAIL wr_bready got=%b required=100", {bready, awvalid, wvalid});
        else n_pass++;
        @(negedge clk); bvalid = 0; #1;
        n_total++;
        if ({data_data_ok, bus_err} !== 2'b10) $display("FAIL wr_data_ok got=%b required=10", {data_data_ok, bus_err});
        else n_pass++;
    endtask

    task automatic test_wstrb;
        logic [1:0]  sz [7];
        logic [31:0] ad [7];
        logic [3:0]  st [7];
        logic [2:0]  az [7];
        sz = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3};
        ad = '{32'h10, 32'h11, 32'h12, 32'h20, 32'h22, 32'h31, 32'h40};
        st = '{4'b0001, 4'b0010, 4'b0100, 4'b0011, 4'b1100, 4'b1111, 4'b1111};
        az = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b010, 3'b011};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); data_req = 1; data_wr = 1; data_size = sz[i]; data_addr = ad[i];
            data_wdata = 32'h0; awready = 1; wready = 1;
            @(negedge clk); data_req = 0; #1;
            n_total++;
            if ({wstrb, awsize, awaddr} !== {st[i], az[i], ad[i]})
                $display("FAIL wstrb_%0d got=%b_%b_%h required=%b_%b_%h", i, wstrb, awsize, awaddr, st[i], az[i], ad[i]);
            else n_pass++;
            @(negedge clk); bvalid = 1;
            @(negedge clk); bvalid = 0; #1;
            n_total++;
            if (data_data_ok !== 1'b1) $display("FAIL wstrb_done_%0d got=%b required=1", i, data_data_ok);
            else n_pass++;
        end
    endtask

    task automatic test_w_before_aw;
        @(negedge clk); data_req = 1; data_wr = 1; data_size = 2'b10; data_addr = 32'h0000_4000;
        data_wdata = 32'h0BAD_F00D; awready = 0; wready = 1;
        @(negedge clk); data_req = 0; #1;
        n_total++;
        if ({awvalid, wvalid} !== 2'b11) $display("FAIL wfirst_c1 got=%b required=11", {awvalid, wvalid});
        else n_pass++;
        for (int c = 2; c <= 3; c++) begin
            @(negedge clk); wready = 0; #1;
            n_total++;
            if ({awvalid, wvalid, bready} !== 3'b100) $display("FAIL wfirst_c%0d got=%b required=100", c, {awvalid, wvalid, bready});
            else n_pass++;
        end
        @(negedge clk); awready = 1; #1;
        n_total++;
        if ({awvalid, wvalid, bready, awaddr} !== {3'b100, 32'h0000_4000})
            $display("FAIL wfirst_c4 got=%b_%h required=100_00004000", {awvalid, wvalid, bready}, awaddr);
        else n_pass++;
        @(negedge clk); awready = 0; bvalid = 1; #1;
        n_total++;
        if ({awvalid, wvalid, bready} !== 3'b001) $display("FAIL wfirst_c5 got=%b required=001", {awvalid, wvalid, bready});
        else n_pass++;
        @(negedge clk); bvalid = 0; #1;
        n_total++;
        if (data_data_ok !== 1'b1) $display("FAIL wfirst_done got=%b required=1", data_data_ok);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        @(negedge clk); data_req = 1; data_wr = 1; data_size = 2'b10; data_addr = 32'h0000_3000;
        data_wdata = 32'h1234_5678; awready = 1; wready = 1;
        @(negedge clk); data_req = 0; #1;
        n_total++;
        if ({awvalid, wvalid, wstrb, wdata} !== {2'b11, 4'b1111, 32'h1234_5678})
            $display("FAIL evict_wr got=%b_%b_%h required=11_1111_12345678", {awvalid, wvalid}, wstrb, wdata);
        else n_pass++;
        @(negedge clk); bvalid = 1; data_req = 1; data_wr = 0; data_addr = 32'h0000_5000; arready = 1; #1;
        n_total++;
        if ({data_addr_ok, bready, arvalid} !== 3'b010) $display("FAIL evict_busy got=%b required=010", {data_addr_ok, bready, arvalid});
        else n_pass++;
        @(negedge clk); bvalid = 0; #1;
        n_total++;
        if ({data_data_ok, data_addr_ok} !== 2'b11) $display("FAIL evict_same_cycle got=%b required=11", {data_data_ok, data_addr_ok});
        else n_pass++;
        @(negedge clk); data_req = 0; #1;
        n_total++;
        if ({arvalid, awvalid, wvalid, data_data_ok, araddr} !== {4'b1000, 32'h0000_5000})
            $display("FAIL evict_rd_ar got=%b_%h required=1000_00005000", {arvalid, awvalid, wvalid, data_data_ok}, araddr);
        else n_pass++;
        @(negedge clk); arready = 0; rvalid = 1; rdata = 32'hCAFE_F00D; rresp = 0;
        @(negedge clk); rvalid = 0; #1;
        n_total++;
        if ({data_data_ok, data_rdata} !== {1'b1, 32'hCAFE_F00D})
            $display("FAIL evict_rd_data got=%b_%h required=1_cafef00d", data_data_ok, data_rdata);
        else n_pass++;
    endtask

    task automatic test_error;
        @(negedge clk); data_req = 1; data_wr = 0; data_size = 2'b10; data_addr = 32'h0000_6000; arready = 1;
        @(negedge clk); data_req = 0;
        @(negedge clk); arready = 0; rvalid = 1; rdata = 32'h1111_2222; rresp = 2'b10;
        @(negedge clk); rvalid = 0; rresp = 0; #1;
        n_total++;
        if ({data_data_ok, bus_err, data_rdata} !== {2'b11, 32'h1111_2222})
            $display("FAIL rerr_pulse got=%b_%h required=11_11112222", {data_data_ok, bus_err}, data_rdata);
        else n_pass++;
        @(negedge clk); data_req = 1; data_wr = 1; data_addr = 32'h0000_7000; awready = 1; wready = 1; #1;
        n_total++;
        if ({data_data_ok, bus_err, data_addr_ok, rready} !== 4'b0010)
            $display("FAIL rerr_idle got=%b required=0010", {data_data_ok, bus_err, data_addr_ok, rready});
        else n_pass++;
        @(negedge clk); data_req = 0;
        @(negedge clk); bvalid = 1; bresp = 2'b11;
        @(negedge clk); bvalid = 0; bresp = 0; #1;
        n_total++;
        if ({data_data_ok, bus_err} !== 2'b11) $display("FAIL berr_pulse got=%b required=11", {data_data_ok, bus_err});
        else n_pass++;
        @(negedge clk); #1;
        n_total++;
        if ({data_data_ok, bus_err} !== 2'b00) $display("FAIL berr_clear got=%b required=00", {data_data_ok, bus_err});
        else n_pass++;
    endtask

    task automatic test_reset_mid_read;
        @(negedge clk); data_req = 1; data_wr = 0; data_size = 2'b10; data_addr = 32'h0000_8000; arready = 1;
        @(negedge clk); data_req = 0;
        @(negedge clk); arready = 0; #1;
        n_total++;
        if (rready !== 1'b1) $display("FAIL rstmid_rd_data got=%b required=1", rready);
        else n_pass++;
        #1 rst = 1'b0; #1;
        n_total++;
        if ({rready, arvalid, data_data_ok, data_rdata} !== 35'h0)
            $display("FAIL rstmid_drop got=%b_%h required=000_00000000", {rready, arvalid, data_data_ok}, data_rdata);
        else n_pass++;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); data_req = 1; data_addr = 32'h0000_9000; arready = 1; #1;
        n_total++;
        if (data_addr_ok !== 1'b1) $display("FAIL rstmid_addr_ok got=%b required=1", data_addr_ok);
        else n_pass++;
        @(negedge clk); data_req = 0;
        @(negedge clk); arready = 0; rvalid = 1; rdata = 32'h5A5A_5A5A;
        @(negedge clk); rvalid = 0; #1;
        n_total++;
        if ({data_data_ok, bus_err, data_rdata} !== {2'b10, 32'h5A5A_5A5A})
            $display("FAIL rstmid_after got=%b_%h required=10_5a5a5a5a", {data_data_ok, bus_err}, data_rdata);
        else n_pass++;
    endtask

    initial begin
        test_reset;
        test_read_basic;
        test_byte_write;
        test_wstrb;
        test_w_before_aw;
        test_back_to_back;
        test_error;
        test_reset_mid_read;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
